uart_rx_controller: RTL

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_controller_if.sv | 66 ++++++
 rtl/uart_rx_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller_if.sv
// ============================================================================
// Module  : uart_rx_controller_if
// Brief   : Config, receiver-handshake and read-side bundle of uart_rx_controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_rx_controller_if #(
  parameter int FIFO_DEPTH          = 16,
  parameter int CLOCK_DIVISOR_WIDTH = 24
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                           cfgWrite;
  logic [1:0]                     cfgDataBits;
  logic                           cfgHasParity;
  logic [1:0]                     cfgParityMode;
  logic                           cfgExtraStopBit;
  logic [CLOCK_DIVISOR_WIDTH-1:0] cfgClockDivisor;
  logic                           rxEnable;

  logic [1:0]                     dataBits;
  logic                           hasParity;
  logic [1:0]                     parityMode;
  logic                           extraStopBit;
  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor;

  logic [8:0]                     rxData;
  logic                           rxDataReceived;
  logic                           rxParityError;
  logic                           rxOverflow;
  logic                           rxBreak;
  logic                           rxSilence;
  logic                           rxReceiveReq;

  logic                           readReq;
  logic [10:0]                    readData;
  logic                           readValid;
  logic [c_CNT_W-1:0]             fifoCount;
  logic                           fifoEmpty;
  logic                           fifoFull;
  logic                           frameEnd;
  logic [7:0]                     errorCount;
  logic                           clearErrors;
  logic                           dropped;

  modport master (
    output cfgWrite, cfgDataBits, cfgHasParity, cfgParityMode, cfgExtraStopBit,
           cfgClockDivisor, rxEnable, rxData, rxDataReceived, rxParityError,
           rxOverflow, rxBreak, rxSilence, readReq, clearErrors,
    input  dataBits, hasParity, parityMode, extraStopBit, clockDivisor,
           rxReceiveReq, readData, readValid, fifoCount, fifoEmpty, fifoFull,
           frameEnd, errorCount, dropped
  );

  modport slave (
    input  cfgWrite, cfgDataBits, cfgHasParity, cfgParityMode, cfgExtraStopBit,
           cfgClockDivisor, rxEnable, rxData, rxDataReceived, rxParityError,
           rxOverflow, rxBreak, rxSilence, readReq, clearErrors,
    output dataBits, hasParity, parityMode, extraStopBit, clockDivisor,
           rxReceiveReq, readData, readValid, fifoCount, fifoEmpty, fifoFull,
           frameEnd, errorCount, dropped
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_controller.sv
// ============================================================================
// Module  : uart_rx_controller
// Brief   : UART receive front end: line config, ack handshake, receive FIFO,
//           error accounting and end-of-frame detection.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_controller #(
  parameter int FIFO_DEPTH          = 16,
  parameter int CLOCK_DIVISOR_WIDTH = 24
) (
  input  wire logic          clk,
  input  wire logic          rstN,
  uart_rx_controller_if.slave bus
);
  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_AW + 1;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_ACK  = 2'd1;
  localparam logic [1:0] c_S_WAIT = 2'd2;

  logic [1:0]                     r_data_bits;
  logic                           r_has_parity;
  logic [1:0]                     r_parity_mode;
  logic                           r_extra_stop;
  logic [CLOCK_DIVISOR_WIDTH-1:0] r_clk_div;

  logic [1:0]         r_state, w_state_nxt;
  logic               w_ack;
  logic               r_break_prev, r_silence_prev;
  logic [10:0]        r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0] r_count, w_count_nxt;
  logic               r_empty, r_full;
  logic [10:0]        r_read_data;
  logic               r_read_valid;
  logic [7:0]         r_err_cnt;
  logic               r_dropped;
  logic               r_pending;
  logic               r_frame_end;

  logic        w_cap_data, w_cap_break, w_push, w_pop, w_write, w_drop;
  logic        w_ovf_err, w_par_err, w_silence_rise;
  logic [10:0] w_entry;
  logic [1:0]  w_err_inc;
  logic [7:0]  w_err_base;
  logic [8:0]  w_err_sum;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_data_bits   <= 2'b11;
      r_has_parity  <= 1'b0;
      r_parity_mode <= 2'b00;
      r_extra_stop  <= 1'b0;
      r_clk_div     <= '0;
    end else if (bus.cfgWrite) begin
      r_data_bits   <= bus.cfgDataBits;
      r_has_parity  <= bus.cfgHasParity;
      r_parity_mode <= bus.cfgParityMode;
      r_extra_stop  <= bus.cfgExtraStopBit;
      r_clk_div     <= bus.cfgClockDivisor;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= c_S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (w_cap_data || w_cap_break) w_state_nxt = c_S_ACK;
      c_S_ACK:  w_state_nxt = c_S_WAIT;
      c_S_WAIT: if (!bus.rxDataReceived && !bus.rxBreak) w_state_nxt = c_S_IDLE;
      default:  w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_ack = (r_state == c_S_ACK);
  end

  // Data wins over a coincident break edge; that break edge is simply lost.
  assign w_cap_data  = (r_state == c_S_IDLE) && bus.rxDataReceived;
  assign w_cap_break = (r_state == c_S_IDLE) && !bus.rxDataReceived &&
                       bus.rxBreak && !r_break_prev;
  assign w_entry     = w_cap_data ? {1'b0, bus.rxParityError, bus.rxData} : 11'h400;
  assign w_push      = (w_cap_data || w_cap_break) && bus.rxEnable;
  assign w_pop       = bus.readReq && !r_empty;
  assign w_write     = w_push && (!r_full || w_pop);
  assign w_drop      = w_push && r_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_write && !w_pop)      w_count_nxt = r_count + c_CNT_W'(1);
    else if (!w_write && w_pop) w_count_nxt = r_count - c_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + c_AW'(1);
        r_read_data <= r_mem[r_rd_ptr];
      end
      r_read_valid <= w_pop;
      r_count      <= w_count_nxt;
      r_empty      <= (w_count_nxt == '0);
      r_full       <= (w_count_nxt == c_CNT_W'(FIFO_DEPTH));
    end
  end

  // Error sources can coincide; their sum is added with saturation at 255.
  assign w_ovf_err  = w_ack && bus.rxOverflow;
  assign w_par_err  = w_write && w_entry[9];
  assign w_err_inc  = {1'b0, w_ovf_err} + {1'b0, w_par_err} + {1'b0, w_drop};
  assign w_err_base = bus.clearErrors ? 8'h00 : r_err_cnt;
  assign w_err_sum  = {1'b0, w_err_base} + {7'b0, w_err_inc};

  assign w_silence_rise = bus.rxSilence && !r_silence_prev;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_err_cnt      <= '0;
      r_dropped      <= 1'b0;
      r_break_prev   <= 1'b0;
      r_silence_prev <= 1'b0;
      r_pending      <= 1'b0;
      r_frame_end    <= 1'b0;
    end else begin
      r_err_cnt      <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
      if (w_drop || w_ovf_err)  r_dropped <= 1'b1;
      else if (bus.clearErrors) r_dropped <= 1'b0;
      r_break_prev   <= bus.rxBreak;
      r_silence_prev <= bus.rxSilence;
      r_frame_end    <= w_silence_rise && r_pending;
      if (w_push)              r_pending <= 1'b1;
      else if (w_silence_rise) r_pending <= 1'b0;
    end
  end

  assign bus.dataBits     = r_data_bits;
  assign bus.hasParity    = r_has_parity;
  assign bus.parityMode   = r_parity_mode;
  assign bus.extraStopBit = r_extra_stop;
  assign bus.clockDivisor = r_clk_div;
  assign bus.rxReceiveReq = w_ack;
  assign bus.readData     = r_read_data;
  assign bus.readValid    = r_read_valid;
  assign bus.fifoCount    = r_count;
  assign bus.fifoEmpty    = r_empty;
  assign bus.fifoFull     = r_full;
  assign bus.frameEnd     = r_frame_end;
  assign bus.errorCount   = r_err_cnt;
  assign bus.dropped      = r_dropped;
endmodule

`default_nettype wire
